// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU arbiter slice.
//   - ALU operation encodings carried in ALU_control[2:1]
//   - bit index of the shift-left-1 flag in ALU_control / Req_op slices
//   - arbiter FSM state type
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Bit 0 of a 3-bit op field requests a shift-left-1 of the ALU result.
  localparam int ALU_SHIFT_BIT = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//   Requester-side bus of the ALU arbiter.
//   Signals:
//     req       NUM_REQ             level request per requester
//     req_op    NUM_REQ*3           per requester {op[1:0], shift}, requester i at [3i+2:3i]
//     req_a     NUM_REQ*DATA_WIDTH  operand A, requester i at slice i
//     req_b     NUM_REQ*DATA_WIDTH  operand B, requester i at slice i
//     gnt       NUM_REQ             one-hot grant, 1-cycle pulse
//     rsp_valid 1                   result valid, 1-cycle pulse
//     rsp_id    ID_WIDTH            requester index of rsp_data
//     rsp_data  DATA_WIDTH          ALU result
//   Handshake: a requester raises req[i] with its op/operands and holds all of
//   them stable until it sees gnt[i]; it drops req[i] within one cycle of gnt.
//   A req still high when the arbiter is next idle counts as a new request;
//   dropping req before gnt withdraws it. Each grant yields exactly one
//   rsp_valid pulse two cycles after gnt, tagged with the granted index,
//   unless reset intervenes.
//   Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*3-1:0]          req_op;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]            gnt;
  logic                          rsp_valid;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req, req_op, req_a, req_b,
    input  gnt, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req, req_op, req_a, req_b,
    output gnt, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/alu_rr_picker.sv
// -----------------------------------------------------------------------------
// alu_rr_picker
//   Combinational round-robin picker: the winner is the first set request
//   strictly after i_ptr, wrapping around.
//   Ports:
//     i_req     NUM_REQ   request vector
//     i_ptr     ID_WIDTH  index of the last winner
//     o_any     1         at least one request set
//     o_idx     ID_WIDTH  winner index (valid when o_any)
//     o_onehot  NUM_REQ   one-hot winner (zero when no request)
// -----------------------------------------------------------------------------
module alu_rr_picker #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic                o_any,
  output logic [ID_WIDTH-1:0] o_idx,
  output logic [NUM_REQ-1:0]  o_onehot
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [31:0]          w_pos;
  logic [31:0]          w_sum;

  // Rotate the request vector so the requester just after i_ptr lands at
  // bit 0; the lowest set bit of the rotated vector is then the winner.
  always_comb begin
    w_dbl = {i_req, i_req} >> (32'(i_ptr) + 32'd1);
    w_rot = w_dbl[NUM_REQ-1:0];
    w_pos = 32'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_pos = 32'(k);
    end
    w_sum = 32'(i_ptr) + 32'd1 + w_pos;
    if (w_sum >= 32'(NUM_REQ)) w_sum = w_sum - 32'(NUM_REQ);
  end

  assign o_any    = |i_req;
  assign o_idx    = w_sum[ID_WIDTH-1:0];
  assign o_onehot = o_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << o_idx) : '0;

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one registered-output ALU between NUM_REQ requesters using
//   round-robin arbitration. One operation every three cycles:
//   IDLE (arbitrate, drive ALU inputs) -> ISSUE (grant pulse, ALU registers
//   result) -> CAPTURE (latch ALU result, raise rsp_valid) -> IDLE.
//   Ports:
//     i_clk          clock, all state on posedge
//     i_rst_n        asynchronous active-low reset
//     bus            alu_arbiter_if.slave requester bus
//     o_alu_control  to ALU: [2:1] op (add/sub/and/or), [0] shift-left-1
//     o_ainput       to ALU operand A
//     o_binput       to ALU operand B
//     i_shift_output from ALU, registered by the ALU on posedge
//     o_dbg_state    current FSM state
//     o_op_count     16-bit wrapping count of responses (only when the
//                    ALU_ARB_OPCOUNT_EN macro is defined)
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  alu_arbiter_if.slave          bus,
  output logic [2:0]            o_alu_control,
  output logic [DATA_WIDTH-1:0] o_ainput,
  output logic [DATA_WIDTH-1:0] o_binput,
  input  logic [DATA_WIDTH-1:0] i_shift_output,
  output state_t                o_dbg_state
`ifdef ALU_ARB_OPCOUNT_EN
  ,
  output logic [15:0]           o_op_count
`endif
);

  localparam int ID_WIDTH = $clog2(NUM_REQ);

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [NUM_REQ-1:0]    r_gnt;
  logic                  r_rsp_valid;
  logic [ID_WIDTH-1:0]   r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [2:0]            r_alu_control;
  logic [DATA_WIDTH-1:0] r_ainput;
  logic [DATA_WIDTH-1:0] r_binput;
`ifdef ALU_ARB_OPCOUNT_EN
  logic [15:0]           r_op_count;
`endif

  logic                  w_any;
  logic [ID_WIDTH-1:0]   w_idx;
  logic [NUM_REQ-1:0]    w_onehot;

  alu_rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_any    (w_any),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  // The pointer doubles as the in-flight winner's index: it is only updated
  // on a grant, so it still names that requester in CAPTURE. Reset value
  // NUM_REQ-1 gives requester 0 first priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= ID_WIDTH'(NUM_REQ - 1);
      r_gnt         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_data    <= '0;
      r_alu_control <= '0;
      r_ainput      <= '0;
      r_binput      <= '0;
`ifdef ALU_ARB_OPCOUNT_EN
      r_op_count    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_valid <= 1'b0;
          if (w_any) begin
            r_gnt         <= w_onehot;
            r_alu_control <= bus.req_op[32'(w_idx) * 3 +: 3];
            r_ainput      <= bus.req_a[32'(w_idx) * DATA_WIDTH +: DATA_WIDTH];
            r_binput      <= bus.req_b[32'(w_idx) * DATA_WIDTH +: DATA_WIDTH];
            r_ptr         <= w_idx;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          // ALU latches its result at this edge from the held inputs.
          r_gnt   <= '0;
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_rsp_data  <= i_shift_output;
          r_rsp_id    <= r_ptr;
          r_rsp_valid <= 1'b1;
`ifdef ALU_ARB_OPCOUNT_EN
          r_op_count  <= r_op_count + 16'd1;
`endif
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign o_alu_control = r_alu_control;
  assign o_ainput      = r_ainput;
  assign o_binput      = r_binput;
  assign o_dbg_state   = r_state;
`ifdef ALU_ARB_OPCOUNT_EN
  assign o_op_count    = r_op_count;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter with a behavioural registered ALU,
//   a vector table, hand-written corner sequences, random traffic and a
//   reference model feeding expected-grant / expected-response queues.
//   Optional feature macro: ALU_ARB_OPCOUNT_EN.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DW      = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT and ALU ----------------
  alu_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  logic [2:0]    alu_control;
  logic [DW-1:0] ainput;
  logic [DW-1:0] binput;
  logic [DW-1:0] shift_output = 16'hA5C3;
  state_t        dbg_state;
`ifdef ALU_ARB_OPCOUNT_EN
  logic [15:0]   op_count;
`endif

  alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .bus            (bus),
    .o_alu_control  (alu_control),
    .o_ainput       (ainput),
    .o_binput       (binput),
    .i_shift_output (shift_output),
    .o_dbg_state    (dbg_state)
`ifdef ALU_ARB_OPCOUNT_EN
    ,
    .o_op_count     (op_count)
`endif
  );

  // Result of one ALU operation, from plain integer arithmetic.
  function automatic logic [DW-1:0] ref_alu(input logic [1:0] op, input logic sh,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint r;
    case (op)
      ALU_ADD: r = longint'(a) + longint'(b);
      ALU_SUB: r = longint'(a) - longint'(b) + 65536;
      ALU_AND: r = longint'(a & b);
      default: r = longint'(a | b);
    endcase
    if (sh) r = r * 2;
    return DW'(r % 65536);
  endfunction

  // External ALU: result registered on posedge, never reset.
  always @(posedge clk) shift_output <= ref_alu(alu_control[2:1], alu_control[0], ainput, binput);

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First requester strictly after 'last', counting round the ring.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Expected-event queues: grant {cycle, id}, response {cycle, id, data}.
  logic [39:0] exp_gnt_q[$];
  logic [55:0] exp_rsp_q[$];
  int cyc     = 0;
  int m_ptr   = NUM_REQ - 1;
  int m_busy  = 0;
  int m_w     = 0;
  int rsp_seen = 0;

  // Reference model: the arbiter is free every third edge; when free and
  // someone requests, the round-robin winner is granted one cycle later and
  // answered three cycles later with the operands seen at that edge.
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ptr  = NUM_REQ - 1;
      m_busy = 0;
      exp_gnt_q.delete();
      exp_rsp_q.delete();
    end else begin
      if (m_busy > 0) m_busy = m_busy - 1;
      else if (bus.req != '0) begin
        m_w = rr_pick(bus.req, m_ptr);
        m_ptr = m_w;
        m_busy = 2;
        exp_gnt_q.push_back({32'(cyc + 1), 8'(m_w)});
        exp_rsp_q.push_back({32'(cyc + 3), 8'(m_w),
                             ref_alu(bus.req_op[3*m_w+1 +: 2], bus.req_op[3*m_w],
                                     bus.req_a[DW*m_w +: DW], bus.req_b[DW*m_w +: DW])});
      end
      cyc = cyc + 1;
    end
  end

  // Monitor: compares every grant and response against the model queues.
  logic [39:0] mon_g;
  logic [55:0] mon_r;
  always begin
    @(negedge clk);
    if (!rst_n) rsp_seen = 0;
    else begin
      if (exp_gnt_q.size() > 0 && int'(exp_gnt_q[0][39:8]) < cyc) begin
        tests++; fails++;
        $display("FAIL mon_gnt_missing: no grant, expected id %0d at cycle %0d", exp_gnt_q[0][7:0], exp_gnt_q[0][39:8]);
        void'(exp_gnt_q.pop_front());
      end
      if (exp_rsp_q.size() > 0 && int'(exp_rsp_q[0][55:24]) < cyc) begin
        tests++; fails++;
        $display("FAIL mon_rsp_missing: no response, expected id %0d at cycle %0d", exp_rsp_q[0][23:16], exp_rsp_q[0][55:24]);
        void'(exp_rsp_q.pop_front());
      end
      if (bus.gnt != '0) begin
        if (exp_gnt_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL mon_gnt_unexpected: got gnt 0x%0h, expected none", bus.gnt);
        end else begin
          mon_g = exp_gnt_q.pop_front();
          check("mon_gnt", 64'(bus.gnt), 64'(1) << mon_g[7:0]);
          check("mon_gnt_cycle", 64'(cyc), 64'(mon_g[39:8]));
        end
      end
      if (bus.rsp_valid) begin
        rsp_seen++;
        check("rsp_gnt_overlap", 64'(bus.gnt), 64'd0);
        if (exp_rsp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL mon_rsp_unexpected: got id %0d data 0x%0h, expected none", bus.rsp_id, bus.rsp_data);
        end else begin
          mon_r = exp_rsp_q.pop_front();
          check("mon_rsp_id", 64'(bus.rsp_id), 64'(mon_r[23:16]));
          check("mon_rsp_data", 64'(bus.rsp_data), 64'(mon_r[15:0]));
          check("mon_rsp_cycle", 64'(cyc), 64'(mon_r[55:24]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    int            id;
    logic [1:0]    op;
    logic          sh;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic set_ops(input int i, input logic [1:0] op, input logic sh,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_op[3*i +: 3] = {op, sh};
    bus.req_a[DW*i +: DW] = a;
    bus.req_b[DW*i +: DW] = b;
  endtask

  task automatic rand_ops(input int i);
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    a = ($urandom_range(0, 5) == 0) ? 16'hFFFF : DW'($urandom);
    b = ($urandom_range(0, 5) == 0) ? 16'h0001 : DW'($urandom);
    set_ops(i, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, b);
  endtask

  // Waits (bounded) for any grant; returns negedges waited.
  task automatic wait_gnt(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < budget);
  endtask

  task automatic wait_rsp(input int budget, inout int n);
    while (!bus.rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One isolated operation from an idle arbiter.
  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    set_ops(v.id, v.op, v.sh, v.a, v.b);
    bus.req[v.id] = 1'b1;
    wait_gnt(10, n);
    check("vec_gnt", 64'(bus.gnt), 64'(1) << v.id);
    check("vec_gnt_latency", 64'(n), 64'd1);
    bus.req[v.id] = 1'b0;
    wait_rsp(12, n);
    check("vec_rsp_latency", 64'(n), 64'd3);
    check("vec_rsp_id", 64'(bus.rsp_id), 64'(v.id));
    check("vec_rsp_data", 64'(bus.rsp_data), 64'(v.exp));
  endtask

  // ---------------- test sequence ----------------
  int exp_order[5] = '{0, 1, 2, 3, 0};
  int order[5];
  int gcyc[5];

  initial begin
    int n;
    int k;
    vecs[0] = '{2, ALU_ADD, 1'b0, 16'h0003, 16'h0004, 16'h0007};
    vecs[1] = '{1, ALU_SUB, 1'b1, 16'h0010, 16'h0001, 16'h001E};
    vecs[2] = '{1, ALU_OR,  1'b1, 16'h8001, 16'h0000, 16'h0002};
    vecs[3] = '{0, ALU_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000};
    vecs[4] = '{3, ALU_AND, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3030};
    vecs[5] = '{0, ALU_SUB, 1'b0, 16'h0000, 16'h0001, 16'hFFFF};
    vecs[6] = '{3, ALU_ADD, 1'b1, 16'h4000, 16'h4000, 16'h0000};
    vecs[7] = '{2, ALU_OR,  1'b0, 16'h1200, 16'h0034, 16'h1234};
    vecs[8] = '{1, ALU_AND, 1'b1, 16'hFFFF, 16'h7FFF, 16'hFFFE};

    // Reset held with every requester asking.
    bus.req    = '1;
    bus.req_op = {NUM_REQ{3'b011}};
    bus.req_a  = {NUM_REQ{16'h1111}};
    bus.req_b  = {NUM_REQ{16'h2222}};
    repeat (4) begin
      @(negedge clk);
      check("rst_gnt", 64'(bus.gnt), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_alu_control", 64'(alu_control), 64'd0);
    end
    check("rst_ainput", 64'(ainput), 64'd0);
    check("rst_binput", 64'(binput), 64'd0);
    check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table of isolated operations.
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Operands changed during ISSUE must not affect the result.
    @(negedge clk);
    set_ops(0, ALU_ADD, 1'b0, 16'h0005, 16'h0006);
    bus.req[0] = 1'b1;
    wait_gnt(10, n);
    check("hold_gnt", 64'(bus.gnt), 64'd1);
    set_ops(0, ALU_OR, 1'b1, 16'h0100, 16'h0200);
    bus.req[0] = 1'b0;
    @(negedge clk);
    n++;
    check("hold_ainput", 64'(ainput), 64'h0005);
    check("hold_binput", 64'(binput), 64'h0006);
    wait_rsp(12, n);
    check("hold_rsp_data", 64'(bus.rsp_data), 64'h000B);
    repeat (2) @(negedge clk);

    // All requesters held high from a fresh reset: 0,1,2,3,0 every 3 cycles.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, ALU_ADD, 1'b0, 16'(i), 16'h0100);
    bus.req = '1;
    for (int j = 0; j < 5; j++) begin order[j] = -1; gcyc[j] = 0; end
    k = 0;
    n = 0;
    while (k < 5 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.gnt != '0) begin
        order[k] = $clog2(bus.gnt);
        gcyc[k] = n;
        k++;
      end
    end
    bus.req = '0;
    for (int j = 0; j < 5; j++) check("rr_order", 64'(order[j]), 64'(exp_order[j]));
    for (int j = 1; j < 5; j++) check("rr_spacing", 64'(gcyc[j] - gcyc[j-1]), 64'd3);
    repeat (5) @(negedge clk);

    // Reset during CAPTURE drops the op; requester 0 wins first afterwards.
    set_ops(3, ALU_ADD, 1'b0, 16'h0AAA, 16'h0001);
    bus.req = 4'b1000;
    wait_gnt(10, n);
    check("mid_gnt", 64'(bus.gnt), 64'h8);
    bus.req = '0;
    @(negedge clk);
    check("mid_state", 64'(dbg_state), 64'(CAPTURE));
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    end
    set_ops(0, ALU_ADD, 1'b0, 16'h0001, 16'h0002);
    bus.req = 4'b1001;
    rst_n = 1'b1;
    wait_gnt(10, n);
    check("post_rst_gnt", 64'(bus.gnt), 64'h1);
    check("post_rst_latency", 64'(n), 64'd1);
    bus.req = '0;
    n = 1;
    wait_rsp(12, n);
    check("post_rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("post_rst_rsp_data", 64'(bus.rsp_data), 64'h0003);
    repeat (2) @(negedge clk);

    // Random traffic with withdrawals, checked by the model and monitor.
    repeat (400) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.gnt[i]) begin
          bus.req[i] = 1'b0;
          rand_ops(i);
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            rand_ops(i);
            bus.req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end
    bus.req = '0;
    repeat (6) @(negedge clk);

    check("gnt_q_drained", 64'(exp_gnt_q.size()), 64'd0);
    check("rsp_q_drained", 64'(exp_rsp_q.size()), 64'd0);
`ifdef ALU_ARB_OPCOUNT_EN
    check("op_count", 64'(op_count), 64'(16'(rsp_seen)));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
